// File: rtl/bldc_commutation_sequencer.sv
// Six-step BLDC commutation scheduler: synchronises the divided clock into ticks
// and runs the align -> open-loop ramp -> run start-up sequence.
module bldc_commutation_sequencer #(
  parameter int unsigned DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               div_clk,
  input  logic               start,
  input  logic               stop,
  input  logic               dir,
  input  logic [DWELL_W-1:0] align_ticks,
  input  logic [DWELL_W-1:0] dwell_start,
  input  logic [DWELL_W-1:0] dwell_target,
  input  logic [DWELL_W-1:0] ramp_dec,
  output logic [2:0]         phase_hi,
  output logic [2:0]         phase_lo,
  output logic [2:0]         step,
  output logic               comm_pulse,
  output logic               busy,
  output logic               running
);

  typedef enum logic [1:0] {IDLE, ALIGN, RAMP, RUN} state_t;

  state_t             state;
  logic               s1, s2, s3;
  logic               tick;
  logic [DWELL_W-1:0] align_cfg, start_cfg, target_cfg, dec_cfg;
  logic [DWELL_W-1:0] cur_dwell, tick_cnt;
  logic [DWELL_W-1:0] lim, ramp_first, ramp_next;
  logic               dwell_done;
  logic [2:0]         step_nxt;

  function automatic logic [DWELL_W-1:0] nz(input logic [DWELL_W-1:0] v);
    return (v == '0) ? DWELL_W'(1) : v;
  endfunction

  function automatic logic [2:0] hi_of(input logic [2:0] s);
    case (s)
      3'd0, 3'd1: hi_of = 3'b001;
      3'd2, 3'd3: hi_of = 3'b010;
      default:    hi_of = 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] lo_of(input logic [2:0] s);
    case (s)
      3'd0, 3'd5: lo_of = 3'b010;
      3'd1, 3'd2: lo_of = 3'b100;
      default:    lo_of = 3'b001;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= div_clk;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign tick = s2 & ~s3;

  always_comb begin
    lim = target_cfg;
    case (state)
      ALIGN:   lim = align_cfg;
      RAMP:    lim = cur_dwell;
      default: lim = target_cfg;
    endcase
    dwell_done = (tick_cnt >= lim - DWELL_W'(1));
    ramp_first = (start_cfg > target_cfg) ? start_cfg : target_cfg;
    // cur_dwell never drops below target_cfg, so the difference cannot underflow
    ramp_next  = (cur_dwell - target_cfg >= dec_cfg) ? cur_dwell - dec_cfg : target_cfg;
    if (dir) step_nxt = (step == 3'd5) ? 3'd0 : step + 3'd1;
    else     step_nxt = (step == 3'd0) ? 3'd5 : step - 3'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      step       <= '0;
      phase_hi   <= '0;
      phase_lo   <= '0;
      comm_pulse <= 1'b0;
      busy       <= 1'b0;
      running    <= 1'b0;
      tick_cnt   <= '0;
      cur_dwell  <= '0;
      align_cfg  <= '0;
      start_cfg  <= '0;
      target_cfg <= '0;
      dec_cfg    <= '0;
    end else begin
      comm_pulse <= 1'b0;
      if (stop) begin
        state    <= IDLE;
        step     <= '0;
        phase_hi <= '0;
        phase_lo <= '0;
        busy     <= 1'b0;
        running  <= 1'b0;
        tick_cnt <= '0;
      end else if (state == IDLE) begin
        if (start) begin
          align_cfg  <= nz(align_ticks);
          start_cfg  <= nz(dwell_start);
          target_cfg <= nz(dwell_target);
          dec_cfg    <= ramp_dec;
          state      <= ALIGN;
          busy       <= 1'b1;
          step       <= '0;
          phase_hi   <= hi_of(3'd0);
          phase_lo   <= lo_of(3'd0);
          tick_cnt   <= '0;
        end
      end else if (tick) begin
        if (dwell_done) begin
          step       <= step_nxt;
          phase_hi   <= hi_of(step_nxt);
          phase_lo   <= lo_of(step_nxt);
          comm_pulse <= 1'b1;
          tick_cnt   <= '0;
          // Leaving ALIGN loads the first ramp dwell; a ramp already at target goes straight to RUN
          if (state == ALIGN) begin
            cur_dwell <= ramp_first;
            state     <= (ramp_first == target_cfg) ? RUN : RAMP;
            running   <= (ramp_first == target_cfg);
          end else if (state == RAMP) begin
            cur_dwell <= ramp_next;
            if (ramp_next == target_cfg) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
        end else begin
          tick_cnt <= tick_cnt + DWELL_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_bldc_commutation_sequencer.sv
// Bench for the BLDC commutation sequencer: a schedule-based reference model
// checked every cycle, plus directed step-length and sequence expectations.
module tb_bldc_commutation_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        div_clk = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        dir = 1'b1;
  logic [15:0] align_ticks = '0;
  logic [15:0] dwell_start = '0;
  logic [15:0] dwell_target = '0;
  logic [15:0] ramp_dec = '0;
  logic [2:0]  phase_hi, phase_lo, step;
  logic        comm_pulse, busy, running;

  int n_cmp = 0;
  int n_bad = 0;

  bldc_commutation_sequencer #(.DWELL_W(16)) dut (
    .clk(clk), .rst(rst), .div_clk(div_clk), .start(start), .stop(stop), .dir(dir),
    .align_ticks(align_ticks), .dwell_start(dwell_start), .dwell_target(dwell_target),
    .ramp_dec(ramp_dec), .phase_hi(phase_hi), .phase_lo(phase_lo), .step(step),
    .comm_pulse(comm_pulse), .busy(busy), .running(running)
  );

  always #5 clk = ~clk;

  // div_clk = clk/10, changing away from the sampling edge
  initial forever begin
    repeat (5) @(negedge clk);
    div_clk = ~div_clk;
  end

  // Reference model: a precomputed list of segment lengths (in ticks) walked tick by tick
  logic [2:0] hi_t[6];
  logic [2:0] lo_t[6];
  int  seg_len[$];
  int  run_from, m_step, m_seg, m_cnt, m_tgt;
  logic m_busy, m_comm, div_prev, r1, r2, tk;

  function automatic int nz(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic int len_of(input int s);
    return (s < seg_len.size()) ? seg_len[s] : m_tgt;
  endfunction

  initial begin
    int cur;
    hi_t = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100};
    lo_t = '{3'b010, 3'b100, 3'b100, 3'b001, 3'b001, 3'b010};
    m_busy = 0; m_comm = 0; m_step = 0; m_seg = 0; m_cnt = 0; m_tgt = 1; run_from = 1;
    div_prev = 0; r1 = 0; r2 = 0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_busy = 0; m_comm = 0; m_step = 0; m_seg = 0; m_cnt = 0;
        div_prev = 0; r1 = 0; r2 = 0;
      end else begin
        tk = r2; r2 = r1; r1 = div_clk & ~div_prev; div_prev = div_clk;
        m_comm = 0;
        if (stop) begin
          m_busy = 0; m_step = 0;
        end else if (!m_busy) begin
          if (start) begin
            m_tgt = nz(int'(dwell_target));
            seg_len.delete();
            seg_len.push_back(nz(int'(align_ticks)));
            cur = nz(int'(dwell_start));
            if (cur < m_tgt) cur = m_tgt;
            seg_len.push_back(cur);
            while (cur != m_tgt && seg_len.size() < 1000) begin
              cur = (cur - int'(ramp_dec) > m_tgt) ? cur - int'(ramp_dec) : m_tgt;
              seg_len.push_back(cur);
            end
            run_from = seg_len.size() - 1;
            m_busy = 1; m_step = 0; m_seg = 0; m_cnt = 0;
          end
        end else if (tk) begin
          m_cnt++;
          if (m_cnt >= len_of(m_seg)) begin
            m_seg++;
            m_cnt = 0;
            m_step = dir ? (m_step + 1) % 6 : (m_step + 5) % 6;
            m_comm = 1;
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, act, lo, hi, $time);
    end
  endtask

  // Per-cycle compare of every output against the model, plus the shoot-through invariant
  always @(negedge clk) begin
    logic [11:0] exp_v;
    exp_v = {m_busy ? hi_t[m_step] : 3'b000, m_busy ? lo_t[m_step] : 3'b000, 3'(m_step),
             m_comm, m_busy, m_busy && (m_seg >= run_from)};
    check("model_outputs", {20'd0, phase_hi, phase_lo, step, comm_pulse, busy, running},
          {20'd0, exp_v});
    check("no_overlap", {29'd0, phase_hi & phase_lo}, 32'd0);
  end

  task automatic wait_comm(output int cyc);
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (comm_pulse) break;
      if (cyc > 2000) begin
        n_cmp++; n_bad++;
        $display("FAIL comm_timeout: got no comm_pulse expected one within 2000 cycles");
        break;
      end
    end
  endtask

  task automatic pulse_start;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic cfg(input int a, input int ds, input int dt, input int dec, input logic d);
    align_ticks = 16'(a); dwell_start = 16'(ds); dwell_target = 16'(dt); ramp_dec = 16'(dec);
    dir = d;
  endtask

  initial begin
    int d;
    int exp_s;
    repeat (3) @(negedge clk);
    check("reset_outputs", {26'd0, phase_hi, step, comm_pulse, busy, running}, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Forward start: align 3, ramp 8 -> 6 -> 4, then run every 4 ticks
    cfg(3, 8, 4, 2, 1'b1);
    pulse_start();
    check("start_pattern", {26'd0, phase_hi, phase_lo}, {26'd0, 3'b001, 3'b010});
    wait_comm(d);
    check_rng("fwd_align_len", d, 15, 35);
    check("fwd_step1", {29'd0, step}, 32'd1);
    wait_comm(d);
    check_rng("fwd_step1_len", d, 79, 81);
    check("fwd_step2", {29'd0, step, running}, {29'd0, 3'd2, 1'b0});
    wait_comm(d);
    check_rng("fwd_step2_len", d, 59, 61);
    check("fwd_step3_run", {28'd0, step, running}, {28'd0, 3'd3, 1'b1});
    exp_s = 3;
    for (int i = 0; i < 3; i++) begin
      wait_comm(d);
      exp_s = (exp_s + 1) % 6;
      check_rng("fwd_run_len", d, 39, 41);
      check("fwd_run_step", {29'd0, step}, 32'(exp_s));
    end
    check("fwd_wrap_step0", {26'd0, step, phase_hi}, {26'd0, 3'd0, 3'b001});

    // Reset mid-RUN drops outputs without waiting for a clock edge
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("async_reset", {26'd0, phase_hi, phase_lo}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Reverse with saturating ramp: 5 ticks then straight to target 3
    cfg(3, 5, 3, 7, 1'b0);
    pulse_start();
    check("rev_restart_step0", {28'd0, step, busy}, {28'd0, 3'd0, 1'b1});
    wait_comm(d);
    check("rev_step5", {28'd0, step, running}, {28'd0, 3'd5, 1'b0});
    wait_comm(d);
    check_rng("rev_step5_len", d, 49, 51);
    check("rev_step4_run", {28'd0, step, running}, {28'd0, 3'd4, 1'b1});
    wait_comm(d);
    check_rng("rev_step4_len", d, 29, 31);
    check("rev_step3", {29'd0, step}, 32'd3);
    wait_comm(d);
    check("rev_step2", {29'd0, step}, 32'd2);

    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("stop_idle", {26'd0, phase_hi, step, busy, running, comm_pulse}, 32'd0);
    repeat (4) @(negedge clk);

    // Zero align and inverted dwell: 1-tick align, RUN on first commutation, 6-tick steps
    cfg(0, 2, 6, 1, 1'b1);
    pulse_start();
    wait_comm(d);
    check_rng("zero_align_len", d, 0, 15);
    check("inv_run_first", {28'd0, step, running}, {28'd0, 3'd1, 1'b1});
    wait_comm(d);
    check_rng("inv_step_len", d, 59, 61);
    check("inv_step2", {29'd0, step}, 32'd2);

    // start in RUN with new config is ignored
    repeat (5) @(negedge clk);
    dwell_target = 16'd2;
    pulse_start();
    check("run_start_ignored", {29'd0, step}, 32'd2);
    repeat (9) @(negedge clk);
    wait_comm(d);
    check_rng("run_start_dwell", d + 15, 59, 61);
    check("run_start_step", {29'd0, step}, 32'd3);

    // Direction change mid-step
    repeat (10) @(negedge clk);
    dir = 1'b0;
    wait_comm(d);
    check("dir_change_step", {29'd0, step}, 32'd2);
    wait_comm(d);
    check("dir_change_step2", {29'd0, step}, 32'd1);

    // stop + start together in RUN
    repeat (7) @(negedge clk);
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check("stop_start_same", {23'd0, phase_hi, phase_lo, step}, 32'd0);
    check("stop_start_flags", {29'd0, busy, running, comm_pulse}, 32'd0);
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
